// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Parity mode encodings match the PARITY parameter of uart_rx.
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Parity bit a correct transmitter would append to d in the given mode.
    function automatic logic exp_parity(input logic [7:0] d, input int mode);
        return (mode == PARITY_ODD) ? ~(^d) : (^d);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO, depth 2**ASIZE.
// Push and pop in the same cycle are both accepted, including when full.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ASIZE      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ASIZE)-1];
    logic [ASIZE:0]        r_wptr;
    logic [ASIZE:0]        r_rptr;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[ASIZE] != r_rptr[ASIZE]) &&
                       (r_wptr[ASIZE-1:0] == r_rptr[ASIZE-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | i_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rptr[ASIZE-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wptr[ASIZE-1:0]] <= i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)
                r_rptr <= r_rptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional parity, 1 stop bit,
// 3-sample majority vote per bit, received bytes queued in a FWFT FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int PARITY     = 0,
    parameter int FIFO_ASIZE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_uart_rx,
    output logic       o_valid,
    output logic [7:0] o_data,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output logic       o_overrun
);

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] S0   = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] S1   = 16'(CLK_DIV / 2);
    localparam logic [15:0] S2   = 16'(CLK_DIV / 2 + 1);

    rx_state_t   r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_rxs_prev;
    logic [15:0] r_cnt;
    logic        r_s0;
    logic        r_s1;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_idx;
    logic        r_par_err;
    logic        r_frame_err;
    logic        r_parity_err;
    logic        r_overrun;

    logic        w_vote;
    logic        w_at_vote;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;

    assign w_vote    = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
    assign w_at_vote = (r_cnt == S2);
    assign w_pop     = o_valid & i_ready;
    assign w_push    = (r_state == STOP) && w_at_vote && w_vote && !r_par_err &&
                       (!w_full || w_pop);

    assign o_valid      = ~w_empty;
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;
    assign o_overrun    = r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rxs_prev <= 1'b1;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
        end else begin
            r_sync1    <= i_uart_rx;
            r_sync2    <= r_sync1;
            r_rxs_prev <= r_sync2;
            if (r_cnt == S0)
                r_s0 <= r_sync2;
            if (r_cnt == S1)
                r_s1 <= r_sync2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= WAIT_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_par_err    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            if (r_state != WAIT_IDLE && r_state != IDLE)
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 16'd1;

            case (r_state)
                // Synchronizer flops reset high, so give them two cycles to
                // reflect the real line before trusting a "high" reading.
                WAIT_IDLE: begin
                    if (r_cnt != 16'd2)
                        r_cnt <= r_cnt + 16'd1;
                    else if (r_sync2) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                end
                IDLE: begin
                    if (r_rxs_prev && !r_sync2) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    if (w_at_vote) begin
                        if (w_vote) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                            r_par_err <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (w_at_vote) begin
                        r_shift   <= {w_vote, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7)
                            r_state <= (PARITY != PARITY_NONE) ? PAR : STOP;
                    end
                end
                PAR: begin
                    if (w_at_vote) begin
                        r_par_err <= (w_vote != exp_parity(r_shift, PARITY));
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    if (w_at_vote) begin
                        r_cnt <= '0;
                        if (!w_vote) begin
                            r_frame_err <= 1'b1;
                            r_state     <= WAIT_IDLE;
                        end else if (r_par_err) begin
                            r_parity_err <= 1'b1;
                            r_state      <= IDLE;
                        end else if (w_full && !w_pop) begin
                            r_overrun <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= WAIT_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    sync_fifo #(
        .DATA_WIDTH (8),
        .ASIZE      (FIFO_ASIZE)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_data  (o_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance without parity, one with even parity,
// CLK_DIV=16 and a 4-deep FIFO.
module tb_uart_rx;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx1 = 1'b1, rx2 = 1'b1;
    logic       ready1 = 1'b0, ready2 = 1'b0;
    logic       valid1, valid2;
    logic [7:0] data1, data2;
    logic       ferr1, perr1, ovr1, ferr2, perr2, ovr2;

    int n_vec = 0;
    int n_mis = 0;
    int n_ferr1 = 0, n_perr1 = 0, n_ovr1 = 0;
    int n_ferr2 = 0, n_perr2 = 0, n_ovr2 = 0;

    always #5 clk = ~clk;

    uart_rx #(.CLK_DIV(DIV), .PARITY(0), .FIFO_ASIZE(2)) dut1 (
        .clk(clk), .rst(rst), .i_uart_rx(rx1), .o_valid(valid1), .o_data(data1),
        .i_ready(ready1), .o_frame_err(ferr1), .o_parity_err(perr1), .o_overrun(ovr1));

    uart_rx #(.CLK_DIV(DIV), .PARITY(2), .FIFO_ASIZE(2)) dut2 (
        .clk(clk), .rst(rst), .i_uart_rx(rx2), .o_valid(valid2), .o_data(data2),
        .i_ready(ready2), .o_frame_err(ferr2), .o_parity_err(perr2), .o_overrun(ovr2));

    always @(posedge clk) begin
        if (ferr1) n_ferr1++;
        if (perr1) n_perr1++;
        if (ovr1)  n_ovr1++;
        if (ferr2) n_ferr2++;
        if (perr2) n_perr2++;
        if (ovr2)  n_ovr2++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input int sel, input logic b);
        if (sel == 1) rx1 = b;
        else          rx2 = b;
    endtask

    // Called at a negedge; leaves the line at the stop-bit level.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic use_par,
                              input logic par, input logic stop);
        set_line(sel, 1'b0);
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, d[i]);
            repeat (DIV) @(negedge clk);
        end
        if (use_par) begin
            set_line(sel, par);
            repeat (DIV) @(negedge clk);
        end
        set_line(sel, stop);
        repeat (DIV) @(negedge clk);
    endtask

    task automatic pop_byte(input int sel, input logic [7:0] exp, input string tag);
        int i;
        i = 0;
        while (i < 400 && !(sel == 1 ? valid1 : valid2)) begin
            @(negedge clk);
            i++;
        end
        check_val({tag, "_valid"}, 32'(sel == 1 ? valid1 : valid2), 32'd1);
        check_val({tag, "_data"}, 32'(sel == 1 ? data1 : data2), 32'(exp));
        if (sel == 1) ready1 = 1'b1; else ready2 = 1'b1;
        @(negedge clk);
        if (sel == 1) ready1 = 1'b0; else ready2 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, p0, o0;

        repeat (3) @(negedge clk);
        check_val("rst_valid1", 32'(valid1), 32'd0);
        check_val("rst_data1", 32'(data1), 32'd0);
        check_val("rst_valid2", 32'(valid2), 32'd0);
        check_val("rst_err1", 32'({ferr1, perr1, ovr1}), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Back-to-back frames
        send_frame(1, 8'h55, 1'b0, 1'b0, 1'b1);
        send_frame(1, 8'hA3, 1'b0, 1'b0, 1'b1);
        pop_byte(1, 8'h55, "b2b_0");
        pop_byte(1, 8'hA3, "b2b_1");
        check_val("b2b_empty", 32'(valid1), 32'd0);
        check_val("b2b_errs", 32'(n_ferr1 + n_perr1 + n_ovr1), 32'd0);

        // Start-bit glitch rejected
        rx1 = 1'b0;
        repeat (4) @(negedge clk);
        rx1 = 1'b1;
        repeat (40) @(negedge clk);
        check_val("glitch_valid", 32'(valid1), 32'd0);
        check_val("glitch_errs", 32'(n_ferr1 + n_perr1 + n_ovr1), 32'd0);
        send_frame(1, 8'h3C, 1'b0, 1'b0, 1'b1);
        pop_byte(1, 8'h3C, "glitch_next");

        // Framing error, line held low, then recovery
        send_frame(1, 8'h7E, 1'b0, 1'b0, 1'b0);
        check_val("ferr_count", 32'(n_ferr1), 32'd1);
        check_val("ferr_nopush", 32'(valid1), 32'd0);
        repeat (100) @(negedge clk);
        check_val("ferr_hold_count", 32'(n_ferr1), 32'd1);
        check_val("ferr_hold_valid", 32'(valid1), 32'd0);
        rx1 = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(1, 8'h81, 1'b0, 1'b0, 1'b1);
        pop_byte(1, 8'h81, "ferr_next");

        // Even parity: 0x01 needs parity bit 1
        send_frame(2, 8'h01, 1'b1, 1'b1, 1'b1);
        pop_byte(2, 8'h01, "par_ok");
        send_frame(2, 8'h01, 1'b1, 1'b0, 1'b1);
        check_val("par_err_count", 32'(n_perr2), 32'd1);
        check_val("par_err_nopush", 32'(valid2), 32'd0);
        check_val("par_other_errs", 32'(n_ferr2 + n_ovr2), 32'd0);

        // Overrun on the fifth byte
        o0 = n_ovr1;
        for (int b = 0; b < 5; b++)
            send_frame(1, 8'(8'h10 + b), 1'b0, 1'b0, 1'b1);
        check_val("ovr_count", 32'(n_ovr1 - o0), 32'd1);
        for (int b = 0; b < 4; b++)
            pop_byte(1, 8'(8'h10 + b), "ovr_pop");
        check_val("ovr_empty", 32'(valid1), 32'd0);

        // Same, but a pop coincides with the fifth stop-bit vote
        o0 = n_ovr1;
        for (int b = 0; b < 4; b++)
            send_frame(1, 8'(8'h10 + b), 1'b0, 1'b0, 1'b1);
        fork
            send_frame(1, 8'h14, 1'b0, 1'b0, 1'b1);
            begin
                repeat (12 + 9 * DIV) @(posedge clk);
                @(negedge clk);
                ready1 = 1'b1;
                @(negedge clk);
                ready1 = 1'b0;
            end
        join
        check_val("ovr_pop_count", 32'(n_ovr1 - o0), 32'd0);
        for (int b = 1; b < 5; b++)
            pop_byte(1, 8'(8'h10 + b), "ovr_pop2");
        check_val("ovr_pop2_empty", 32'(valid1), 32'd0);

        // Reset mid-frame with two bytes queued
        send_frame(1, 8'h20, 1'b0, 1'b0, 1'b1);
        send_frame(1, 8'h21, 1'b0, 1'b0, 1'b1);
        check_val("mid_queued", 32'(valid1), 32'd1);
        f0 = n_ferr1;
        p0 = n_perr1;
        fork
            send_frame(1, 8'h00, 1'b0, 1'b0, 1'b1);
            begin
                repeat (5 * DIV + 5) @(posedge clk);
                @(negedge clk);
                rst = 1'b1;
                #1;
                check_val("mid_rst_valid", 32'(valid1), 32'd0);
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        check_val("mid_after_valid", 32'(valid1), 32'd0);
        send_frame(1, 8'hE7, 1'b0, 1'b0, 1'b1);
        pop_byte(1, 8'hE7, "mid_e7");
        check_val("mid_alone", 32'(valid1), 32'd0);
        check_val("mid_errs", 32'((n_ferr1 - f0) + (n_perr1 - p0)), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
